// File: rtl/gauss_pkg.sv
// Shared constants and types for the 3x3 Gaussian window filter.
// Kernel is the separable [1 2 1] x [1 2 1] / 16.
package gauss_pkg;

    localparam int CH_W    = 8;
    localparam int NUM_CH  = 3;
    localparam int WIDTH_W = 11;

    localparam int W_EDGE = 1;
    localparam int W_SIDE = 2;
    // Centre weight is W_SIDE*W_SIDE, realised by the separable sums.
    localparam int W_CTR  = W_SIDE * W_SIDE;

    localparam int ROUND = 8;
    localparam int SHIFT = 4;

    localparam int HSUM_W = CH_W + 2;
    localparam int VSUM_W = CH_W + 4;

    typedef struct packed {
        logic v;
        logic e;
    } vld_t;

    function automatic logic [HSUM_W-1:0] hsum(
        input logic [CH_W-1:0] l,
        input logic [CH_W-1:0] m,
        input logic [CH_W-1:0] r
    );
        return HSUM_W'(l) * HSUM_W'(W_EDGE)
             + HSUM_W'(m) * HSUM_W'(W_SIDE)
             + HSUM_W'(r) * HSUM_W'(W_EDGE);
    endfunction

endpackage

// File: rtl/gaussian_window_conv_kernel.sv
// One colour channel of the 3x3 kernel: row sums, then a
// rounded column sum. Two register stages.
module gauss_kernel_ch
    import gauss_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      h_en_i,
    input  logic                      v_en_i,
    input  logic [2:0][2:0][CH_W-1:0] px_i,
    output logic [CH_W-1:0]           px_o
);

    logic [2:0][HSUM_W-1:0] h_q;
    logic [VSUM_W-1:0]      v_d;
    logic [CH_W-1:0]        px_q;

    // Stage 1: horizontal weighted sum of each window row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q <= '0;
        end else if (h_en_i) begin
            for (int r = 0; r < 3; r++) begin
                h_q[r] <= hsum(px_i[r][0], px_i[r][1], px_i[r][2]);
            end
        end
    end

    // Vertical weighted sum plus rounding; max 4088 fits VSUM_W.
    always_comb begin
        v_d = VSUM_W'(h_q[0]) * VSUM_W'(W_EDGE)
            + VSUM_W'(h_q[1]) * VSUM_W'(W_SIDE)
            + VSUM_W'(h_q[2]) * VSUM_W'(W_EDGE)
            + VSUM_W'(ROUND);
    end

    // Stage 2: scaled result, held while no valid output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_q <= '0;
        end else if (v_en_i) begin
            px_q <= v_d[SHIFT +: CH_W];
        end
    end

    assign px_o = px_q;

endmodule

// File: rtl/gaussian_window_conv.sv
// 3x3 Gaussian window builder and filter fed by two line buffers.
// Emits interior pixels only, three cycles after the input column.
module gaussian_window_conv #(
    parameter int CH_W    = gauss_pkg::CH_W,
    parameter int NUM_CH  = gauss_pkg::NUM_CH,
    parameter int WIDTH_W = gauss_pkg::WIDTH_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH_W-1:0]       img_width,
    input  logic                     sof_i,
    input  logic                     valid_i,
    input  logic [CH_W*NUM_CH-1:0]   row0_i,
    input  logic [CH_W*NUM_CH-1:0]   row1_i,
    input  logic [CH_W*NUM_CH-1:0]   row2_i,
    output logic                     valid_o,
    output logic [CH_W*NUM_CH-1:0]   data_o,
    output logic                     eol_o
);
    import gauss_pkg::*;

    localparam int PIX_W = CH_W * NUM_CH;

    logic [WIDTH_W-1:0]          col_cnt_q, col_cnt_d;
    logic [WIDTH_W-1:0]          width_q, width_d;
    logic [WIDTH_W-1:0]          col_eff, w_eff;
    logic                        last_col;
    logic [2:0][2:0][PIX_W-1:0]  win_q;
    vld_t                        p1_q, p1_d, p2_q;
    logic                        valid_q, eol_q;

    // Column position and line width; sof forces column 0.
    always_comb begin
        col_eff   = sof_i ? '0 : col_cnt_q;
        w_eff     = (col_eff == '0) ? img_width : width_q;
        last_col  = (col_eff == w_eff - 1'b1);
        col_cnt_d = col_cnt_q;
        width_d   = width_q;
        p1_d      = '0;
        if (valid_i) begin
            width_d   = w_eff;
            col_cnt_d = last_col ? '0 : col_eff + 1'b1;
            p1_d.v    = (col_eff >= WIDTH_W'(2))
                     && (w_eff >= WIDTH_W'(3));
            p1_d.e    = last_col;
        end
    end

    // Counter, sampled width and first valid/eol stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_cnt_q <= '0;
            width_q   <= '0;
            p1_q      <= '0;
        end else begin
            col_cnt_q <= col_cnt_d;
            width_q   <= width_d;
            p1_q      <= p1_d;
        end
    end

    // Column shift registers: index 2 is the newest column.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q <= '0;
        end else if (valid_i) begin
            win_q[0] <= {row0_i, win_q[0][2], win_q[0][1]};
            win_q[1] <= {row1_i, win_q[1][2], win_q[1][1]};
            win_q[2] <= {row2_i, win_q[2][2], win_q[2][1]};
        end
    end

    // Valid/eol pipeline aligned with the kernel stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p2_q    <= '0;
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            p2_q    <= p1_q;
            valid_q <= p2_q.v;
            eol_q   <= p2_q.v && p2_q.e;
        end
    end

    for (genvar g_ch = 0; g_ch < NUM_CH; g_ch++) begin : g_chan
        logic [2:0][2:0][CH_W-1:0] px;

        // Slice this channel out of the 3x3 pixel window.
        always_comb begin
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    px[r][k] = win_q[r][k][g_ch*CH_W +: CH_W];
                end
            end
        end

        gauss_kernel_ch u_kernel (
            .clk    (clk),
            .reset  (reset),
            .h_en_i (p1_q.v),
            .v_en_i (p2_q.v),
            .px_i   (px),
            .px_o   (data_o[g_ch*CH_W +: CH_W])
        );
    end

    assign valid_o = valid_q;
    assign eol_o   = eol_q;

endmodule

// File: tb/tb_gaussian_window_conv.sv
// Randomised scoreboard bench for gaussian_window_conv.
// Reference model keeps whole lines and applies the 3x3 kernel directly.
module tb_gaussian_window_conv;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] img_width = '0;
    logic        sof_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [23:0] row0_i = '0;
    logic [23:0] row1_i = '0;
    logic [23:0] row2_i = '0;
    logic        valid_o;
    logic [23:0] data_o;
    logic        eol_o;

    gaussian_window_conv dut (
        .clk       (clk),
        .reset     (reset),
        .img_width (img_width),
        .sof_i     (sof_i),
        .valid_i   (valid_i),
        .row0_i    (row0_i),
        .row1_i    (row1_i),
        .row2_i    (row2_i),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .eol_o     (eol_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] d;
        bit          eol;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] last_exp = '0;

    logic [23:0] lt[$];
    logic [23:0] lm[$];
    logic [23:0] lb[$];
    int          mw = 0;
    int          kw[3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    function automatic void model_clear();
        lt.delete();
        lm.delete();
        lb.delete();
    endfunction

    // One accepted column: store it in the current line and, once three
    // columns of an eligible line exist, predict the filtered pixel.
    function automatic void model_col(bit sof, int w, logic [23:0] a,
                                      logic [23:0] b, logic [23:0] c,
                                      int at);
        exp_t        e;
        int          n;
        int          s;
        logic [23:0] px[3][3];
        if (sof || lt.size() == 0) begin
            model_clear();
            mw = w;
        end
        lt.push_back(a);
        lm.push_back(b);
        lb.push_back(c);
        n = lt.size();
        if (n >= 3 && mw >= 3) begin
            for (int j = 0; j < 3; j++) begin
                px[0][j] = lt[n-3+j];
                px[1][j] = lm[n-3+j];
                px[2][j] = lb[n-3+j];
            end
            e.d = '0;
            for (int ch = 0; ch < 3; ch++) begin
                s = 0;
                for (int r = 0; r < 3; r++) begin
                    for (int j = 0; j < 3; j++) begin
                        s += kw[r][j] * int'(px[r][j][8*ch +: 8]);
                    end
                end
                e.d[8*ch +: 8] = 8'((s + 8) / 16);
            end
            e.eol = (n == mw);
            e.cyc = at + 3;
            exp_q.push_back(e);
        end
        if (n == mw) model_clear();
    endfunction

    function automatic logic [23:0] pat(int kind, int c, int r);
        case (kind)
            0: return 24'h808080;
            1: return (r == 1 && c == 3) ? 24'h00FF00 : 24'h0;
            2: return (r == 0 && c == 3) ? 24'hFF0000 : 24'h0;
            3: return 24'hFFFFFF;
            default: return 24'($urandom);
        endcase
    endfunction

    task automatic idle(input int n);
        valid_i = 1'b0;
        sof_i   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_col(input bit sof, input int w,
                             input logic [23:0] a, input logic [23:0] b,
                             input logic [23:0] c, input int gap);
        while ($urandom_range(99) < gap) begin
            valid_i   = 1'b0;
            sof_i     = 1'($urandom);
            img_width = 11'($urandom_range(15, 1));
            row0_i    = 24'($urandom);
            row1_i    = 24'($urandom);
            row2_i    = 24'($urandom);
            @(posedge clk);
            #1;
        end
        valid_i   = 1'b1;
        sof_i     = sof;
        img_width = 11'(w);
        row0_i    = a;
        row1_i    = b;
        row2_i    = c;
        model_col(sof, w, a, b, c, cyc);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        sof_i   = 1'b0;
    endtask

    // Width is only meaningful at column 0; other columns carry junk.
    task automatic line(input int w, input int ncols, input int kind,
                        input bit sof, input int gap);
        for (int c = 0; c < ncols; c++) begin
            drive_col(sof && c == 0,
                      (c == 0) ? w : int'($urandom_range(15, 1)),
                      pat(kind, c, 0), pat(kind, c, 1),
                      pat(kind, c, 2), gap);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        model_clear();
        last_exp = '0;
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_eol", 32'(eol_o), 32'd0);
        reset = 1'b0;
    endtask

    // Monitor: pops a prediction for every valid_o, flags late ones.
    always @(negedge clk) begin
        exp_t e;
        if (valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data", 32'(data_o), 32'(e.d));
                chk("eol", 32'(eol_o), 32'(e.eol));
                chk("latency", 32'(cyc), 32'(e.cyc));
                last_exp = e.d;
            end
        end else begin
            chk("hold", 32'(data_o), 32'(last_exp));
            chk("eol_idle", 32'(eol_o), 32'd0);
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                chk("missing_valid", 32'(valid_o), 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int  w;
        int  nc;
        bit  need_sof;
        #1;
        do_reset();
        idle(2);

        line(8, 8, 0, 1'b1, 0);
        idle(6);

        line(8, 8, 1, 1'b1, 0);
        idle(6);

        line(8, 8, 2, 1'b1, 0);
        line(8, 8, 3, 1'b1, 0);
        idle(6);

        line(3, 3, 4, 1'b1, 0);
        repeat (3) line(3, 3, 4, 1'b0, 0);
        idle(4);
        line(2, 2, 4, 1'b1, 0);
        repeat (3) line(2, 2, 4, 1'b0, 0);
        line(1, 1, 4, 1'b1, 0);
        idle(4);

        repeat (3) line(8, 8, 1, 1'b1, 33);
        idle(6);

        line(8, 5, 4, 1'b1, 0);
        do_reset();
        line(8, 8, 1, 1'b1, 0);
        idle(6);
        line(8, 5, 4, 1'b1, 0);
        line(8, 8, 4, 1'b1, 0);
        idle(6);

        need_sof = 1'b1;
        for (int i = 0; i < 30; i++) begin
            w  = int'($urandom_range(12, 1));
            nc = ($urandom_range(3) == 0) ? int'($urandom_range(w, 1)) : w;
            line(w, nc, 4, need_sof || ($urandom_range(3) == 0), 33);
            need_sof = (nc != w);
        end

        idle(10);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
